// File: rtl/morse_pkg.sv
// morse_pkg: shared state codes, interval lengths and code-field offsets for the Morse path.
package morse_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYM_ON   = 3'd1,
    S_SYM_GAP  = 3'd2,
    S_CHAR_GAP = 3'd3,
    S_DONE     = 3'd4
  } state_e;
  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int SYM_GAP_UNITS  = 1;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int PAT_LSB        = 0;
  localparam int LEN_LSB        = 5;
  // Returns {found, index of lowest set bit}; index is 0 when nothing is set.
  function automatic logic [3:0] first_set(input logic [7:0] v);
    first_set = 4'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) first_set = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/morse_tone_gen.sv
// morse_tone_gen: square-wave tone with half-period half_i; clr_i restarts the wave high.
module morse_tone_gen #(
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [HW-1:0] half_i,
  output logic          tone_o
);
  logic [HW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d, wrap;
  always_comb begin
    wrap   = cnt_q >= half_i - HW'(1);
    cnt_d  = (clr_i || wrap) ? '0 : cnt_q + HW'(1);
    tone_d = clr_i ? 1'b1 : wrap ? ~tone_q : tone_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end
  assign tone_o = tone_q;
endmodule

// File: rtl/morse_play_sched.sv
// morse_play_sched: sequences stored Morse characters into timed dot/dash/gap intervals
// and drives the buzzer, lending it to the key sidetone while idle.
module morse_play_sched
  import morse_pkg::*;
#(
  parameter int UNIT_BASE = 10_000_000,
  parameter int TONE_BASE = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] codes,
  input  logic [7:0]  char_en,
  input  logic [2:0]  speed_choose,
  input  logic [7:0]  freq_choose,
  input  logic        side_req,
  output logic        beep,
  output logic        busy,
  output logic        done,
  output logic [2:0]  char_idx,
  output logic [2:0]  state
);
  localparam int DW = $clog2(3 * UNIT_BASE * 8 + 1);
  localparam int HW = $clog2(TONE_BASE * 8 + 1);
  state_e        state_q, state_d;
  logic [63:0]   codes_q;
  logic [7:0]    en_q, frq_q, play_live, play_q, code;
  logic [2:0]    spd_q, idx_q, idx_d, sym_q, sym_d, len, fk;
  logic [4:0]    pat;
  logic [3:0]    first_live, next_hi;
  logic [DW-1:0] cnt_q, cnt_d, lim;
  logic [HW-1:0] half;
  logic          side_req_q, latch, dash, more_sym, last, tone, tone_clr;
  int            units;
  always_comb begin
    play_live = '0;
    play_q    = '0;
    for (int i = 0; i < 8; i++) begin
      play_live[i] = char_en[i] && codes[8*i+LEN_LSB +: 3] != 3'd0;
      play_q[i]    = en_q[i] && codes_q[8*i+LEN_LSB +: 3] != 3'd0;
    end
  end
  always_comb begin
    code       = codes_q[{idx_q, 3'b000} +: 8];
    pat        = code[PAT_LSB +: 5];
    len        = code[LEN_LSB +: 3] > 3'd5 ? 3'd5 : code[LEN_LSB +: 3];
    dash       = pat[sym_q];
    more_sym   = sym_q + 3'd1 < len;
    first_live = first_set(play_live);
    // Only characters strictly above the current index are candidates.
    next_hi    = first_set(play_q & ~((8'd2 << idx_q) - 8'd1));
    units      = state_q == S_SYM_ON ? (dash ? DASH_UNITS : DOT_UNITS) :
                 state_q == S_SYM_GAP ? SYM_GAP_UNITS : CHAR_GAP_UNITS;
    lim        = DW'(UNIT_BASE * (int'(spd_q) + 1) * units - 1);
    last       = cnt_q == lim;
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q + DW'(1);
    latch   = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      sym_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start && !abort) begin
            latch   = 1'b1;
            idx_d   = first_live[2:0];
            sym_d   = '0;
            state_d = first_live[3] ? S_SYM_ON : S_DONE;
          end
        end
        S_SYM_ON: if (last) begin
          cnt_d = '0;
          if (more_sym) begin
            state_d = S_SYM_GAP;
            sym_d   = sym_q + 3'd1;
          end else state_d = next_hi[3] ? S_CHAR_GAP : S_DONE;
        end
        S_SYM_GAP: if (last) begin
          cnt_d   = '0;
          state_d = S_SYM_ON;
        end
        S_CHAR_GAP: if (last) begin
          cnt_d   = '0;
          state_d = S_SYM_ON;
          idx_d   = next_hi[2:0];
          sym_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sym_q      <= '0;
      cnt_q      <= '0;
      codes_q    <= '0;
      en_q       <= '0;
      spd_q      <= '0;
      frq_q      <= '0;
      side_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sym_q      <= sym_d;
      cnt_q      <= cnt_d;
      side_req_q <= side_req;
      if (latch) begin
        codes_q <= codes;
        en_q    <= char_en;
        spd_q   <= speed_choose;
        frq_q   <= freq_choose;
      end
    end
  end
  // Idle sidetone follows the live pitch; playback uses the pitch latched at start.
  always_comb begin
    fk       = 3'(first_set(state_q == S_IDLE ? freq_choose : frq_q));
    half     = HW'(TONE_BASE * (int'(fk) + 1));
    tone_clr = (state_d == S_SYM_ON && state_q != S_SYM_ON) ||
               (state_q == S_IDLE && side_req && !side_req_q);
  end
  morse_tone_gen #(.HW(HW)) u_tone (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tone_clr),
    .half_i (half),
    .tone_o (tone)
  );
  assign beep     = tone && (state_q == S_SYM_ON || (state_q == S_IDLE && side_req_q));
  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign char_idx = idx_q;
  assign state    = state_q;
endmodule

// File: tb/tb_morse_play_sched.sv
// tb_morse_play_sched: directed scenarios for the Morse playback scheduler with small unit/tone bases.
module tb_morse_play_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, side_req = 1'b0;
  logic [63:0] codes = '0;
  logic [7:0]  char_en = '0, freq_choose = '0;
  logic [2:0]  speed_choose = '0;
  logic        beep, busy, done;
  logic [2:0]  char_idx, state;
  int          n_chk = 0, n_fail = 0;
  logic [2:0]  st_l [64];
  logic [2:0]  ix_l [64];
  logic        bp_l [64];
  logic        bs_l [64];
  logic        dn_l [64];

  morse_play_sched #(.UNIT_BASE(4), .TONE_BASE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .codes(codes),
    .char_en(char_en), .speed_choose(speed_choose), .freq_choose(freq_choose),
    .side_req(side_req), .beep(beep), .busy(busy), .done(done),
    .char_idx(char_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      st_l[i] = state;
      ix_l[i] = char_idx;
      bp_l[i] = beep;
      bs_l[i] = busy;
      dn_l[i] = done;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(2);
    n_chk++;
    if ({state, beep, busy, done, char_idx} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {state, beep, busy, done, char_idx});
    end
    rst = 1'b0;
    tick(2);
    n_chk++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d expected 0", state);
    end
  endtask

  task automatic test_single_dot();
    int nb, nd;
    logic [2:0] es;
    logic eb;
    codes = 64'h20; char_en = 8'h01; speed_choose = 3'd0; freq_choose = 8'h00;
    pulse_start();
    capture(8);
    nb = 0; nd = 0;
    for (int i = 0; i < 8; i++) begin
      es = i < 4 ? 3'd1 : i == 4 ? 3'd4 : 3'd0;
      eb = i < 4 ? ((i / 2) % 2 == 0) : 1'b0;
      nb += int'(bs_l[i]);
      nd += int'(dn_l[i]);
      n_chk++;
      if (st_l[i] !== es) begin
        n_fail++;
        $display("FAIL dot_state[%0d]: got %0d expected %0d", i, st_l[i], es);
      end
      n_chk++;
      if (bp_l[i] !== eb) begin
        n_fail++;
        $display("FAIL dot_beep[%0d]: got %0d expected %0d", i, bp_l[i], eb);
      end
    end
    n_chk++;
    if (nb != 5) begin
      n_fail++;
      $display("FAIL dot_busy_cycles: got %0d expected 5", nb);
    end
    n_chk++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL dot_done_pulses: got %0d expected 1", nd);
    end
  endtask

  task automatic test_dot_dash();
    int nb;
    logic [2:0] es;
    codes = 64'h42; char_en = 8'h01; speed_choose = 3'd1; freq_choose = 8'h00;
    pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    capture(44);
    nb = 1;
    for (int i = 0; i < 44; i++) begin
      es = i < 7 ? 3'd1 : i < 15 ? 3'd2 : i < 39 ? 3'd1 : i == 39 ? 3'd4 : 3'd0;
      nb += int'(bs_l[i]);
      n_chk++;
      if (st_l[i] !== es) begin
        n_fail++;
        $display("FAIL A_state[%0d]: got %0d expected %0d", i + 1, st_l[i], es);
      end
    end
    n_chk++;
    if (nb != 41) begin
      n_fail++;
      $display("FAIL A_busy_cycles: got %0d expected 41", nb);
    end
    n_chk++;
    if ({bp_l[10], bp_l[15], bp_l[16], bp_l[17], bp_l[18]} !== 5'b01100) begin
      n_fail++;
      $display("FAIL A_dash_beep: got %b expected 01100",
               {bp_l[10], bp_l[15], bp_l[16], bp_l[17], bp_l[18]});
    end
    tick(2);
  endtask

  task automatic test_char_gap();
    logic [2:0] es;
    codes = 64'h0000_0000_0020_2020; char_en = 8'b0000_0101; speed_choose = 3'd0;
    pulse_start();
    capture(22);
    for (int i = 0; i < 22; i++) begin
      es = i < 4 ? 3'd1 : i < 16 ? 3'd3 : i < 20 ? 3'd1 : i == 20 ? 3'd4 : 3'd0;
      n_chk++;
      if (st_l[i] !== es) begin
        n_fail++;
        $display("FAIL gap_state[%0d]: got %0d expected %0d", i, st_l[i], es);
      end
    end
    n_chk++;
    if ({ix_l[0], ix_l[16], ix_l[21]} !== {3'd0, 3'd2, 3'd0}) begin
      n_fail++;
      $display("FAIL gap_char_idx: got %0d,%0d,%0d expected 0,2,0", ix_l[0], ix_l[16], ix_l[21]);
    end
  endtask

  task automatic test_abort();
    int nd;
    codes = 64'h21; char_en = 8'h01; speed_choose = 3'd0;
    pulse_start();
    capture(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_chk++;
    if ({state, beep, busy, done} !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 0", {state, beep, busy, done});
    end
    capture(4);
    nd = 0;
    for (int i = 0; i < 4; i++) nd += int'(dn_l[i]);
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d expected 0", nd);
    end
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    n_chk++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got %0d expected 0", state);
    end
    pulse_start();
    capture(14);
    n_chk++;
    if ({st_l[0], st_l[11], st_l[12], st_l[13]} !== {3'd1, 3'd1, 3'd4, 3'd0}) begin
      n_fail++;
      $display("FAIL restart_after_abort: got %0d,%0d,%0d,%0d expected 1,1,4,0",
               st_l[0], st_l[11], st_l[12], st_l[13]);
    end
  endtask

  task automatic test_sidetone();
    logic eb;
    freq_choose = 8'h04;
    side_req = 1'b1;
    n_chk++;
    if (beep !== 1'b0) begin
      n_fail++;
      $display("FAIL side_delay: got %0d expected 0", beep);
    end
    tick(1);
    capture(14);
    for (int i = 0; i < 14; i++) begin
      eb = (i / 6) % 2 == 0;
      n_chk++;
      if (bp_l[i] !== eb) begin
        n_fail++;
        $display("FAIL side_beep[%0d]: got %0d expected %0d", i, bp_l[i], eb);
      end
    end
    codes = 64'h20; char_en = 8'h01; speed_choose = 3'd0; freq_choose = 8'h02;
    pulse_start();
    freq_choose = 8'h01;
    capture(5);
    n_chk++;
    if ({bp_l[0], bp_l[1], bp_l[2], bp_l[3], bp_l[4]} !== 5'b11110) begin
      n_fail++;
      $display("FAIL preempt_beep: got %b expected 11110",
               {bp_l[0], bp_l[1], bp_l[2], bp_l[3], bp_l[4]});
    end
    n_chk++;
    if ({st_l[0], st_l[4]} !== {3'd1, 3'd4}) begin
      n_fail++;
      $display("FAIL preempt_state: got %0d,%0d expected 1,4", st_l[0], st_l[4]);
    end
    side_req = 1'b0;
    freq_choose = 8'h00;
    tick(3);
  endtask

  task automatic test_empty();
    int nb, nd, nbp;
    codes = 64'h20; char_en = 8'h00;
    pulse_start();
    capture(4);
    nb = 0; nd = 0; nbp = 0;
    for (int i = 0; i < 4; i++) begin
      nb += int'(bs_l[i]);
      nd += int'(dn_l[i]);
      nbp += int'(bp_l[i]);
    end
    n_chk++;
    if (st_l[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL empty_state: got %0d expected 4", st_l[0]);
    end
    n_chk++;
    if ({nb, nd, nbp} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL empty_counts: got busy %0d done %0d beep %0d expected 1 1 0", nb, nd, nbp);
    end
  endtask

  task automatic test_async_reset();
    codes = 64'h0000_0000_0020_0000; char_en = 8'h04; speed_choose = 3'd0;
    pulse_start();
    n_chk++;
    if ({state, char_idx, beep} !== {3'd1, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset: got %0d,%0d,%0d expected 1,2,1", state, char_idx, beep);
    end
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({state, beep, busy, done, char_idx} !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0", {state, beep, busy, done, char_idx});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_dot();
    tick(2);
    test_dot_dash();
    test_char_gap();
    tick(2);
    test_abort();
    tick(2);
    test_sidetone();
    test_empty();
    tick(2);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
